// File: rtl/obstacle_spawner.sv
// -----------------------------------------------------------------------------
// obstacle_spawner
//
// Purpose:
//   Turns one 13-bit LFSR sample per obstacle into a gap length (in frame
//   ticks), an obstacle type and an obstacle height. It counts the gap down on
//   frame ticks and emits a one-cycle spawn pulse when the gap runs out. This
//   block is the only reader of the random stream, so every obstacle gets a
//   fresh sample.
//
// Optional feature macro:
//   SPAWN_DIFFICULTY_EN - adds the level[1:0] input. The random gap offset is
//                         shifted right by level, so higher levels give denser
//                         spawns. When undefined, the level port does not
//                         exist and the offset is the raw 6-bit random field.
//
// Parameters:
//   MIN_GAP       minimum ticks between spawns (legal 1..192, fits 8 bits)
//
// Ports:
//   clock          in   1   system clock, rising edge
//   reset          in   1   asynchronous active-high reset
//   tick           in   1   frame-tick strobe, one clock wide
//   enable         in   1   game running; low forces idle with no spawns
//   rnd            in  13   current random word from the generator
//   level          in   2   difficulty (only with SPAWN_DIFFICULTY_EN)
//   spawn          out  1   one-cycle spawn pulse
//   spawn_type     out  2   obstacle type, held after the pulse
//   spawn_height   out  3   obstacle height, held after the pulse
//   gap_remaining  out  8   ticks left before the next spawn
//   spawn_count    out  8   spawns since reset, wraps 255 -> 0
// -----------------------------------------------------------------------------
module obstacle_spawner #(
  parameter int MIN_GAP = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        enable,
  input  logic [12:0] rnd,
`ifdef SPAWN_DIFFICULTY_EN
  input  logic [1:0]  level,
`endif
  output logic        spawn,
  output logic [1:0]  spawn_type,
  output logic [2:0]  spawn_height,
  output logic [7:0]  gap_remaining,
  output logic [7:0]  spawn_count
);

  localparam logic [7:0] MIN_GAP_W = 8'(MIN_GAP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    FIRE = 2'd3
  } state_t;

  state_t     state;

  // Type and height captured in LOAD, presented on the outputs only when the
  // spawn actually fires so the outputs keep describing the last obstacle.
  logic [1:0] pending_type;
  logic [2:0] pending_height;

  // ---------------------------------------------------------------------------
  // Random sample decoding (only meaningful in the LOAD cycle).
  // An all-zero word is the LFSR lock-up state; it is replaced by 13'h000F,
  // which gives offset 15 and type/height 0. Only the fields actually used are
  // extracted, the zero test covers the remaining bits.
  // ---------------------------------------------------------------------------
  logic       rnd_zero;
  logic [5:0] sample_offset;
  logic [1:0] sample_type;
  logic [2:0] sample_height;
  logic [5:0] gap_offset;
  logic [7:0] load_gap;

  always_comb begin
    rnd_zero      = (rnd == 13'd0);
    sample_offset = rnd_zero ? 6'h0F : rnd[5:0];
    sample_type   = rnd_zero ? 2'd0  : rnd[8:7];
    sample_height = rnd_zero ? 3'd0  : rnd[11:9];
`ifdef SPAWN_DIFFICULTY_EN
    gap_offset    = sample_offset >> level;
`else
    gap_offset    = sample_offset;
`endif
    // MIN_GAP <= 192 and offset <= 63, so this 8-bit sum never wraps.
    load_gap      = MIN_GAP_W + {2'b00, gap_offset};
  end

  // The edge-qualified "last tick" of a gap. gap_remaining can never be 0 in
  // WAIT because MIN_GAP >= 1, but treating 0 like 1 avoids a stuck state.
  logic last_tick;

  always_comb begin
    last_tick = tick && (gap_remaining <= 8'd1);
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pending_type   <= 2'd0;
      pending_height <= 3'd0;
      spawn          <= 1'b0;
      spawn_type     <= 2'd0;
      spawn_height   <= 3'd0;
      gap_remaining  <= 8'd0;
      spawn_count    <= 8'd0;
    end else if (!enable) begin
      // Disabling abandons the current gap entirely; re-enabling always takes
      // a new sample. A spawn that would have fired on this edge is dropped,
      // so neither spawn nor spawn_count reflect it.
      state         <= IDLE;
      spawn         <= 1'b0;
      gap_remaining <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          spawn <= 1'b0;
          state <= LOAD;
        end

        LOAD: begin
          spawn          <= 1'b0;
          pending_type   <= sample_type;
          pending_height <= sample_height;
          gap_remaining  <= load_gap;
          state          <= WAIT;
        end

        WAIT: begin
          spawn <= 1'b0;
          if (last_tick) begin
            // Type/height, the pulse and the count all move together on the
            // edge that enters FIRE, so the count always matches the pulses
            // that were actually seen.
            gap_remaining <= 8'd0;
            spawn         <= 1'b1;
            spawn_type    <= pending_type;
            spawn_height  <= pending_height;
            spawn_count   <= spawn_count + 8'd1;
            state         <= FIRE;
          end else if (tick) begin
            gap_remaining <= gap_remaining - 8'd1;
          end
        end

        FIRE: begin
          // Ticks here are not counted toward the next gap.
          spawn <= 1'b0;
          state <= LOAD;
        end

        default: begin
          spawn <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Consumer of the 13-bit LFSR random word: it reads one random sample per obstacle and converts it into a gap length in frame ticks, an obstacle type and an obstacle height. It then emits a one-cycle spawn pulse when the gap expires. It sits between the random generator and the obstacle/scroll logic of the game and is the only reader of the random stream.

## Interface
Parameters:
- MIN_GAP, 32: minimum ticks between spawns; legal range 1..192, so the gap fits in 8 bits.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; forces every register to its reset value immediately.
- tick  input  1  frame-tick strobe, one clock wide.
- enable  input  1  game running; low means idle and no spawns.
- rnd  input  13  current random word from the generator.
- spawn  output  1  one-cycle spawn pulse.
- spawn_type  output  2  obstacle type, valid while spawn is high and held afterwards.
- spawn_height  output  3  obstacle height, valid while spawn is high and held afterwards.
- gap_remaining  output  8  ticks left before the next spawn.
- spawn_count  output  8  total spawns since reset; wraps from 255 to 0.
- level  input  2  difficulty; present only with SPAWN_DIFFICULTY_EN.

## Operation
- Reset values: the state is IDLE, and spawn, spawn_type, spawn_height, gap_remaining and spawn_count are all 0.
- States: IDLE, LOAD, WAIT, FIRE.
- IDLE:
  - While enable=0, stay in IDLE.
  - When enable=1 is sampled, go to LOAD.
- LOAD (always exactly one cycle): sample rnd into an internal word r and go to WAIT.
  - If rnd==0 (illegal LFSR state), substitute r = 13'h000F.
  - gap = MIN_GAP + g, computed 8 bits wide; the sum cannot overflow because MIN_GAP ≤ 192 and g ≤ 63.
  - g = r[5:0] without the macro; see Configuration for the macro case.
  - Store r[8:7] as the pending type and r[11:9] as the pending height.
  - gap_remaining takes the value gap on the LOAD edge.
- WAIT:
  - On each tick with gap_remaining > 1, decrement gap_remaining.
  - On a tick with gap_remaining == 1, set gap_remaining to 0 and go to FIRE. On that same edge, set spawn=1 and load spawn_type and spawn_height from the pending values.
- FIRE (always exactly one cycle):
  - spawn is high for this cycle only.
  - spawn_count increments by 1 and wraps.
  - Go to LOAD, so a fresh rnd is read for every obstacle.
- Ticks seen in LOAD or FIRE are ignored and are not counted toward any gap.
- enable=0 sampled in any state:
  - The next state is IDLE and spawn is forced to 0.
  - gap_remaining clears to 0.
  - spawn_type, spawn_height and spawn_count hold their values.
  - If enable falls on the edge that would enter FIRE, the spawn is suppressed and spawn_count does not increment.
- enable returning to 1 always restarts with LOAD, i.e. a new random sample. No partial gap is resumed.

## Timing
- Enable sampled high at edge N: LOAD during cycle N+1, and gap_remaining = gap after edge N+1.
- Spawn latency: spawn rises on the edge that samples the gap-th tick seen in WAIT, and falls on the following edge.
- Minimum spacing between spawn pulses: 2 cycles of LOAD/FIRE overhead plus gap ticks.
- rnd is sampled only in the LOAD cycle. Changes on rnd in any other cycle have no effect.
- Reset asserted mid-gap or during FIRE: all outputs go to their reset values asynchronously; spawn drops in the same cycle.

## Configuration
- SPAWN_DIFFICULTY_EN:
  - Defined: the level[1:0] input exists and g = r[5:0] >> level. At level 3, g ranges 0..7, so spawns get denser as level rises. level is sampled in LOAD only.
  - Undefined: the level port is absent and g = r[5:0].
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then enable=1 with rnd=13'h1A85 and MIN_GAP=32:
  - After LOAD, gap_remaining=37.
  - spawn fires on the 37th tick with spawn_type=2'b01 and spawn_height=3'd5.
  - spawn_count=1 afterwards.
- rnd=13'h0000 at LOAD -> substitute 13'h000F is used, so gap=47, type=0, height=0.
- Tick asserted in every clock cycle with rnd=13'h0001:
  - Each spawn-to-spawn period is 33 ticks of WAIT plus 2 overhead cycles (35 cycles).
  - spawn is never high for two consecutive cycles.
- enable dropped at gap_remaining=10:
  - The next cycle is IDLE, gap_remaining=0 and no spawn occurs.
  - Re-enabling with rnd=13'h003F gives gap_remaining=95.
- Async reset during the FIRE cycle -> spawn and spawn_count are 0 immediately, without waiting for a clock edge.
- With SPAWN_DIFFICULTY_EN, level=3 and rnd=13'h003F -> gap=39. Without the macro, the same rnd gives gap=95.
- 256 spawns -> spawn_count wraps to 0.
